// File: rtl/cache_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and width helpers for the direct-mapped,
//                write-through cache controller (cache_ctrl) and its line
//                store (cache_line_store).
//  Contents    : cache_state_t  - controller FSM state encoding
//                off_bits       - word-offset field width
//                idx_bits       - line-index field width
//                tag_bits       - tag field width within a 30-bit word address
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // A 32-bit byte address yields a 30-bit word address.
  localparam int WORD_ADDR_BITS = 30;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COMPARE   = 3'd1,
    ST_FILL      = 3'd2,
    ST_RESPOND   = 3'd3,
    ST_WRITE_MEM = 3'd4
  } cache_state_t;

  function automatic int off_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int num_lines, input int words_per_line);
    return WORD_ADDR_BITS - $clog2(num_lines) - $clog2(words_per_line);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_store.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cache_line_store
//  Description : Valid bits, tags and data words for a direct-mapped cache.
//                Combinational read port addressed by (index, offset);
//                single write port that can write one data word, mark a
//                whole line valid with a new tag, or invalidate a line.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                rd_index/rd_offset  - read address
//                rd_valid/rd_tag     - state of the addressed line
//                rd_data             - addressed data word
//                wr_index            - line targeted by every write action
//                wr_en/wr_offset/wr_data - data word write
//                set_en/set_tag      - mark line valid with tag
//                inval_en            - clear line valid bit
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_line_store
  import cache_pkg::*;
#(
  parameter  int NUM_LINES      = 8,
  parameter  int WORDS_PER_LINE = 4,
  localparam int OB             = off_bits(WORDS_PER_LINE),
  localparam int IB             = idx_bits(NUM_LINES),
  localparam int TAGW           = tag_bits(NUM_LINES, WORDS_PER_LINE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IB-1:0]   rd_index,
  input  logic [OB-1:0]   rd_offset,
  output logic            rd_valid,
  output logic [TAGW-1:0] rd_tag,
  output logic [31:0]     rd_data,
  input  logic [IB-1:0]   wr_index,
  input  logic            wr_en,
  input  logic [OB-1:0]   wr_offset,
  input  logic [31:0]     wr_data,
  input  logic            set_en,
  input  logic [TAGW-1:0] set_tag,
  input  logic            inval_en
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAGW-1:0]      tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*WORDS_PER_LINE];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[{rd_index, rd_offset}];

  // Only the valid bits need clearing; tags and data are meaningless
  // while their line is invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[wr_index] <= 1'b1;
    end else if (inval_en) begin
      valid_q[wr_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (set_en) begin
      tag_q[wr_index] <= set_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[{wr_index, wr_offset}] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cache_ctrl
//  Description : Direct-mapped, write-through, no-write-allocate cache
//                controller in front of a word-addressed RAM with active-low
//                enables. Read misses fill a whole line (one read issued per
//                cycle, data captured one cycle later); every write is
//                forwarded to the RAM. Counts read hits and misses.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                cpu_req/we/bw/addr/wdata - CPU request (held until cpu_ready)
//                cpu_rdata/cpu_ready      - CPU response, one-cycle pulse
//                mem_addr/mem_data        - RAM word address / shared data bus
//                mem_ce_n/oe_n/we_n/bw    - RAM controls (bw: 0 = low byte)
//                hit_count/miss_count     - read hit / miss counters
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int          NUM_LINES      = 8,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_bw,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_bw,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OB   = off_bits(WORDS_PER_LINE);
  localparam int IB   = idx_bits(NUM_LINES);
  localparam int TAGW = tag_bits(NUM_LINES, WORDS_PER_LINE);
  // Fill counter runs 0..WORDS_PER_LINE: W issue cycles plus one drain cycle.
  localparam int FCW  = $clog2(WORDS_PER_LINE + 1);

  cache_state_t state, state_nxt;

  // Request latches
  logic [31:0] addr_q;
  logic        we_q;
  logic        bw_q;
  logic [31:0] wdata_q;

  logic [FCW-1:0] fill_cnt;

  // Address decomposition of the latched request
  logic [31:0]     word_diff;
  logic [29:0]     word_addr;
  logic [OB-1:0]   w_off;
  logic [IB-1:0]   w_idx;
  logic [TAGW-1:0] w_tag;

  assign word_diff = addr_q - BASE_ADDR;
  assign word_addr = word_diff[31:2];
  assign w_off     = word_addr[OB-1:0];
  assign w_idx     = word_addr[OB+IB-1:OB];
  assign w_tag     = word_addr[29:OB+IB];

  // Line store interface
  logic            ls_valid;
  logic [TAGW-1:0] ls_tag;
  logic [31:0]     ls_data;
  logic            ls_wr_en;
  logic [OB-1:0]   ls_wr_off;
  logic [31:0]     ls_wr_data;
  logic            ls_set_en;
  logic            ls_inval_en;

  logic           hit;
  logic           fill_issue;
  logic           fill_last;
  logic [FCW-1:0] cap_cnt;
  logic [OB-1:0]  cap_off;

  assign hit        = ls_valid && (ls_tag == w_tag);
  assign fill_issue = (fill_cnt < FCW'(WORDS_PER_LINE));
  assign fill_last  = (fill_cnt == FCW'(WORDS_PER_LINE));
  // The word arriving on mem_data now was issued in the previous cycle.
  assign cap_cnt    = fill_cnt - FCW'(1);
  assign cap_off    = cap_cnt[OB-1:0];

  assign ls_wr_en    = ((state == ST_FILL) && (fill_cnt != '0)) ||
                       ((state == ST_COMPARE) && we_q && bw_q && hit);
  assign ls_wr_off   = (state == ST_FILL) ? cap_off : w_off;
  assign ls_wr_data  = (state == ST_FILL) ? mem_data : wdata_q;
  assign ls_set_en   = (state == ST_FILL) && fill_last;
  // A byte write would leave a stale mix in the line; drop the line instead.
  assign ls_inval_en = (state == ST_COMPARE) && we_q && !bw_q && hit;

  cache_line_store #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_line_store (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (w_idx),
    .rd_offset (w_off),
    .rd_valid  (ls_valid),
    .rd_tag    (ls_tag),
    .rd_data   (ls_data),
    .wr_index  (w_idx),
    .wr_en     (ls_wr_en),
    .wr_offset (ls_wr_off),
    .wr_data   (ls_wr_data),
    .set_en    (ls_set_en),
    .set_tag   (w_tag),
    .inval_en  (ls_inval_en)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (cpu_req) state_nxt = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (we_q)     state_nxt = ST_WRITE_MEM;
        else if (hit) state_nxt = ST_IDLE;
        else          state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (fill_last) state_nxt = ST_RESPOND;
      end
      ST_RESPOND:   state_nxt = ST_IDLE;
      ST_WRITE_MEM: state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  logic mem_drive;

  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_ce_n  = 1'b1;
    mem_oe_n  = 1'b1;
    mem_we_n  = 1'b1;
    mem_bw    = 1'b1;
    mem_drive = 1'b0;
    mem_addr  = {2'b00, word_addr};
    unique case (state)
      ST_COMPARE: begin
        if (!we_q && hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = ls_data;
        end
      end
      ST_FILL: begin
        mem_addr = {2'b00, w_tag, w_idx, fill_cnt[OB-1:0]};
        if (fill_issue) begin
          mem_ce_n = 1'b0;
          mem_oe_n = 1'b0;
        end
      end
      ST_RESPOND: begin
        cpu_ready = 1'b1;
        cpu_rdata = ls_data;
      end
      ST_WRITE_MEM: begin
        mem_ce_n  = 1'b0;
        mem_we_n  = 1'b0;
        mem_bw    = bw_q;
        mem_drive = 1'b1;
        cpu_ready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign mem_data = mem_drive ? wdata_q : 'z;

  // --------------------------------------------------------------------------
  // Request latches, fill counter and hit/miss counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      bw_q       <= 1'b1;
      wdata_q    <= '0;
      fill_cnt   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if ((state == ST_IDLE) && cpu_req) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        bw_q    <= cpu_bw;
        wdata_q <= cpu_wdata;
      end
      if (state == ST_COMPARE) begin
        fill_cnt <= '0;
        if (!we_q) begin
          if (hit) hit_count  <= hit_count + 32'd1;
          else     miss_count <= miss_count + 32'd1;
        end
      end
      if (state == ST_FILL) begin
        fill_cnt <= fill_cnt + FCW'(1);
      end
    end
  end

  // Byte-offset bits and the counter's top bit carry no information here.
  logic unused_ok;
  assign unused_ok = &{1'b0, word_diff[1:0], cap_cnt};

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cache_ctrl
//  Description : Directed self-checking bench for cache_ctrl with a
//                registered-read RAM model on the shared data bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_bw;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;
  logic        mem_ce_n, mem_oe_n, mem_we_n, mem_bw;
  logic [31:0] hit_count, miss_count;

  int total = 0;
  int bad   = 0;

  cache_ctrl #(
    .NUM_LINES      (8),
    .WORDS_PER_LINE (4),
    .BASE_ADDR      (32'h1001_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_bw     (cpu_bw),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ce_n   (mem_ce_n),
    .mem_oe_n   (mem_oe_n),
    .mem_we_n   (mem_we_n),
    .mem_bw     (mem_bw),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // An undriven bus floats high, so any DUT drive of zeros is visible.
  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup (mem_data[g]);
  end

  // --------------------------------------------------------------------------
  // RAM model: registered read (data on the bus the cycle after the issue),
  // write commits on the edge where ce_n=we_n=0.
  // --------------------------------------------------------------------------
  logic [31:0] ram [64];
  logic [31:0] ram_q;
  logic        ram_drive;
  int          cyc;
  logic        log_clr;
  int          rd_n;
  int          ce_cnt;
  logic [31:0] rd_addr [8];
  int          rd_cyc  [8];

  assign mem_data = ram_drive ? ram_q : 32'hzzzz_zzzz;

  function automatic logic [31:0] ram_init(input int i);
    case (i)
      0:       return 32'h0000_00B0;
      4:       return 32'h0000_00A0;
      5:       return 32'h0000_00A1;
      6:       return 32'h0000_00A2;
      7:       return 32'h0000_00A3;
      16:      return 32'h0000_00D0;
      32:      return 32'h0000_00C0;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= ram_init(i);
      ram_drive <= 1'b0;
      ram_q     <= '0;
    end else begin
      ram_drive <= 1'b0;
      if (!mem_ce_n && !mem_oe_n) begin
        ram_q     <= ram[mem_addr[5:0]];
        ram_drive <= 1'b1;
      end
      if (!mem_ce_n && !mem_we_n) begin
        if (mem_bw) ram[mem_addr[5:0]]      <= mem_data;
        else        ram[mem_addr[5:0]][7:0] <= mem_data[7:0];
      end
    end
    if (log_clr) begin
      rd_n   <= 0;
      ce_cnt <= 0;
    end else begin
      if (!mem_ce_n) ce_cnt <= ce_cnt + 1;
      if (!mem_ce_n && !mem_oe_n && rd_n < 8) begin
        rd_addr[rd_n] <= mem_addr;
        rd_cyc[rd_n]  <= cyc;
        rd_n          <= rd_n + 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus rules checked every cycle once out of the initial reset.
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("oe_we_excl", mem_oe_n | mem_we_n, 1'b1);
      if (mem_we_n && !ram_drive) check("bus_undriven", mem_data, 32'hFFFF_FFFF);
    end
  end

  // --------------------------------------------------------------------------
  // One CPU transaction; captures what was visible in the cpu_ready cycle.
  // --------------------------------------------------------------------------
  int          op_lat;
  logic        op_ok;
  logic [31:0] op_rdata, op_maddr, op_mdata;
  logic        op_bw, op_we_n;

  task automatic run_op(input logic we, input logic bw,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    log_clr = 1'b1;
    @(posedge clk); #1;
    log_clr   = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_bw    = bw;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    op_ok     = 1'b0;
    op_lat    = 0;
    n         = 0;
    while (n < 20 && !op_ok) begin
      @(posedge clk); #1;
      n++;
      if (cpu_ready) begin
        op_ok    = 1'b1;
        op_lat   = n;
        op_rdata = cpu_rdata;
        op_bw    = mem_bw;
        op_we_n  = mem_we_n;
        op_maddr = mem_addr;
        op_mdata = mem_data;
      end
    end
    check("op_done", op_ok, 1'b1);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("ready_pulse", cpu_ready, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_bw = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; log_clr = 1'b1; cyc = 0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_ce",    mem_ce_n, 1'b1);
    check("rst_oe",    mem_oe_n, 1'b1);
    check("rst_we",    mem_we_n, 1'b1);
    check("rst_bw",    mem_bw, 1'b1);
    check("rst_data",  mem_data, 32'hFFFF_FFFF);
    check("rst_ready", cpu_ready, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_hits",  hit_count, 32'd0);
    check("rst_miss",  miss_count, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Cold read miss: word 6, line words 4..7
    run_op(1'b0, 1'b1, 32'h1001_0018, 32'h0);
    check("miss_lat",   op_lat, 7);
    check("miss_rdata", op_rdata, 32'h0000_00A2);
    check("miss_cnt",   miss_count, 32'd1);
    check("fill_nrd",   rd_n, 4);
    for (int i = 0; i < 4; i++) begin
      check("fill_addr", rd_addr[i], 32'd4 + 32'(i));
      check("fill_seq",  rd_cyc[i] - rd_cyc[0], i);
    end

    // Read hit in the freshly filled line
    run_op(1'b0, 1'b1, 32'h1001_0014, 32'h0);
    check("hit_lat",   op_lat, 1);
    check("hit_rdata", op_rdata, 32'h0000_00A1);
    check("hit_noram", ce_cnt, 0);
    check("hit_cnt",   hit_count, 32'd1);

    // Word write hit, then read back from the cache
    run_op(1'b1, 1'b1, 32'h1001_0010, 32'hDEAD_BEEF);
    check("wr_lat",   op_lat, 2);
    check("wr_we_n",  op_we_n, 1'b0);
    check("wr_bw",    op_bw, 1'b1);
    check("wr_maddr", op_maddr, 32'd4);
    check("wr_mdata", op_mdata, 32'hDEAD_BEEF);
    check("wr_ram",   ram[4], 32'hDEAD_BEEF);
    check("wr_cnt",   hit_count + miss_count, 32'd2);
    run_op(1'b0, 1'b1, 32'h1001_0010, 32'h0);
    check("rbw_lat",   op_lat, 1);
    check("rbw_rdata", op_rdata, 32'hDEAD_BEEF);
    check("rbw_hits",  hit_count, 32'd2);

    // Byte write invalidates the line; next read refills
    run_op(1'b1, 1'b0, 32'h1001_0010, 32'hFFFF_FF12);
    check("bw_lat",  op_lat, 2);
    check("bw_bw",   op_bw, 1'b0);
    check("bw_ram",  ram[4], 32'hDEAD_BE12);
    run_op(1'b0, 1'b1, 32'h1001_0010, 32'h0);
    check("bwr_lat",   op_lat, 7);
    check("bwr_rdata", op_rdata, 32'hDEAD_BE12);
    check("bwr_miss",  miss_count, 32'd2);

    // Conflict on index 0: tag 0, tag 1, tag 0
    run_op(1'b0, 1'b1, 32'h1001_0000, 32'h0);
    check("cf0_rdata", op_rdata, 32'h0000_00B0);
    run_op(1'b0, 1'b1, 32'h1001_0080, 32'h0);
    check("cf1_rdata", op_rdata, 32'h0000_00C0);
    check("cf1_addr",  rd_addr[0], 32'd32);
    run_op(1'b0, 1'b1, 32'h1001_0000, 32'h0);
    check("cf2_rdata", op_rdata, 32'h0000_00B0);
    check("cf2_lat",   op_lat, 7);
    check("cf_miss",   miss_count, 32'd5);
    check("cf_hits",   hit_count, 32'd2);

    // Reset during the third FILL cycle
    log_clr = 1'b1;
    @(posedge clk); #1;
    log_clr  = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_bw   = 1'b1;
    cpu_addr = 32'h1001_0040;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mf_oe_fill", mem_oe_n, 1'b0);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("mf_ce",   mem_ce_n, 1'b1);
    check("mf_oe",   mem_oe_n, 1'b1);
    check("mf_miss", miss_count, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 1'b1, 32'h1001_0040, 32'h0);
    check("mf_rd_lat",   op_lat, 7);
    check("mf_rd_rdata", op_rdata, 32'h0000_00D0);
    check("mf_rd_miss",  miss_count, 32'd1);
    check("mf_rd_hits",  hit_count, 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller sitting directly upstream of the word-addressed data RAM. Accepts single-word CPU read/write requests and serves read hits from its line store. Fills whole lines from the RAM on read misses and forwards every write straight to the RAM using the RAM's active-low chip/output/write enables and byte-write strobe. Also keeps hit/miss counters for cache-behaviour analysis.

## Interface
- NUM_LINES, 8, number of lines; power of two.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, ≥2.
- BASE_ADDR, 32'h10010000, CPU byte address mapped to RAM word 0.
- clk  in  1  single clock; everything is on posedge.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  request valid; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_bw  in  1  0 = byte write (low byte), 1 = full word; same polarity as RAM `bw`.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_addr  out  32  RAM word address = (cpu_addr − BASE_ADDR) >> 2, line-aligned during fills.
- mem_data  inout  32  RAM data bus; driven only in WRITE_MEM, else 'Z.
- mem_ce_n, mem_oe_n, mem_we_n  out  1 each  active-low RAM enables.
- mem_bw  out  1  RAM byte-write strobe (0 = byte).
- hit_count, miss_count  out  32 each  read hit/miss counters, wrap at 2^32.

## Operation
- Word address w = (cpu_addr − BASE_ADDR) >> 2; offset = w[OB-1:0], index = next IB bits, tag = remaining upper bits. OB = log2(WORDS_PER_LINE), IB = log2(NUM_LINES). No range check is performed.
- FSM states: IDLE, COMPARE, FILL, RESPOND, WRITE_MEM.
- IDLE: if cpu_req, latch addr/we/bw/wdata and go to COMPARE. Otherwise stay.
- COMPARE, read hit: cpu_rdata = line word, cpu_ready = 1, hit_count++, go to IDLE.
- COMPARE, read miss: miss_count++, go to FILL.
- COMPARE, write: go to WRITE_MEM. On a word-write hit, update the cached word. On a byte-write hit, clear the line's valid bit. A write miss does not allocate.
- FILL: issue reads for words base..base+W−1, one per cycle, with mem_ce_n=0 and mem_oe_n=0. Capture mem_data one cycle after each issue. Total W+1 cycles. After the last capture, set valid and tag and go to RESPOND.
- RESPOND: cpu_rdata = filled word at offset, cpu_ready = 1, go to IDLE.
- WRITE_MEM: for one cycle drive mem_ce_n=0, mem_we_n=0, mem_bw=latched bw, mem_addr=w, mem_data=wdata. Assert cpu_ready in the same cycle, then go to IDLE.
- Writes do not change the counters.
- CPU inputs must be held stable until cpu_ready. cpu_req outside IDLE is ignored.

## Timing
- Reset (synchronous) sets:
  - state = IDLE and all valid bits = 0;
  - mem_ce_n = mem_oe_n = mem_we_n = 1, mem_bw = 1, mem_data = 'Z;
  - cpu_ready = 0, cpu_rdata = 0, counters = 0.
- Reset mid-FILL aborts the fill: the line stays invalid and the RAM enables deassert from the next cycle.
- Read hit: cpu_ready appears 1 cycle after the acceptance edge (2 cycles request→ready).
- Read miss: ready appears at acceptance + 1 (COMPARE) + W+1 (FILL) + 1 (RESPOND). For W=4 that is 7 cycles after acceptance.
- Write: ready appears 2 cycles after acceptance; the RAM commits at the WRITE_MEM edge.
- mem_oe_n and mem_we_n are never both low. mem_data is undriven in every state except WRITE_MEM.
- A new request is accepted in the cycle after cpu_ready, so back-to-back operation is allowed.

## Structure
- Package `cache_pkg`: state enum `cache_state_t`, and functions for OB/IB/tag widths derived from parameters.
- Sub-module `cache_line_store`: valid, tag and data arrays. One read port (index, offset). One write port with word write, whole-line valid/tag set, and invalidate. Synchronous clear on rst.
- cache_ctrl holds the FSM, request latches, fill counter, tristate driver and counters.

## Test plan
- Reset: assert rst 2 cycles → all mem_*_n = 1, mem_data Z, cpu_ready = 0, counters = 0.
- Cold read miss of 0x10010018, RAM words 4..7 = 0xA0..0xA3:
  - RAM sees reads at addresses 4, 5, 6, 7 on consecutive cycles;
  - cpu_rdata = 0xA2 with ready 7 cycles after acceptance;
  - miss_count = 1.
- Read 0x10010014 after that fill → hit, rdata = 0xA1, ready 2 cycles after request, no RAM enables, hit_count = 1.
- Word write 0xDEADBEEF to 0x10010010 (hit), then read the same address:
  - RAM word 4 = 0xDEADBEEF;
  - read hits and returns 0xDEADBEEF.
- Byte write (bw=0) 0x12 to 0x10010010 → mem_bw = 0 in the write cycle; the next read of it misses and refills.
- Conflict: read 0x10010000, then 0x10010080 (same index, different tag), then 0x10010000 again → three misses. Also assert rst in the 3rd FILL cycle → line invalid and the next read misses.
